lcd_text_driver: RTL

Downstream display stage for the rotary/register front end. Holds a 32-character text buffer (2 lines × 16) written one byte at a time by the control logic. Runs the HD44780 4-bit power-on initialisation on the starter-board character LCD, then continuously refreshes both display lines from the buffer. The LCD is write-only; busy-flag polling is not used, and all delays are timed by counters.

---
 rtl/lcd_text_pkg.sv | 51 +++++
 rtl/lcd_nibble_writer.sv | 83 ++++++++
 rtl/lcd_text_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_pkg.sv
// Shared constants, state types and default timing for the character LCD text driver.
package lcd_text_pkg;

    localparam int TIMER_W   = 20;
    localparam int BUF_DEPTH = 32;

    localparam int DEF_T_POWERUP    = 750000;
    localparam int DEF_T_4100US     = 205000;
    localparam int DEF_T_100US      = 5000;
    localparam int DEF_T_40US       = 2000;
    localparam int DEF_T_1640US     = 82000;
    localparam int DEF_T_E_HIGH     = 12;
    localparam int DEF_T_NIBBLE_GAP = 50;

    localparam logic [7:0] CMD_FUNC_SET = 8'h28;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_NIB,
        CFG,
        CLR_WAIT,
        REF_ADDR,
        REF_CHAR
    } lcd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_WAIT
    } writer_phase_t;

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_ENTRY;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // Buffer indices 16-31 belong to the second display line.
    function automatic logic [7:0] line_cmd(input logic [4:0] idx);
        return idx[4] ? CMD_LINE2 : CMD_LINE1;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one 4-bit LCD transfer with its enable strobe, then idles for a caller-chosen delay.
module lcd_nibble_writer
    import lcd_text_pkg::*;
#(
    parameter int T_E_HIGH = DEF_T_E_HIGH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         nibble,
    input  logic               rs,
    input  logic [TIMER_W-1:0] wait_cycles,
    output logic               done,
    output logic [3:0]         lcd_d,
    output logic               lcd_e,
    output logic               lcd_rs
);

    localparam int XFER_LEN = T_E_HIGH + 4;

    writer_phase_t      phase, phase_n;
    logic [TIMER_W-1:0] cnt, cnt_n;
    logic [TIMER_W-1:0] wait_q;
    logic               accept;
    logic               e_n;

    // done marks the final cycle, so a new start can follow with no dead cycle.
    assign done   = (phase == W_XFER && cnt == TIMER_W'(XFER_LEN - 1) && wait_q == '0)
                 || (phase == W_WAIT && cnt == wait_q - 1'b1);
    assign accept = start && (phase == W_IDLE || done);

    // NOTE: every signal written here gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        phase_n = phase;
        cnt_n   = cnt;
        unique case (phase)
            W_XFER: begin
                if (cnt == TIMER_W'(XFER_LEN - 1)) begin
                    phase_n = (wait_q == '0) ? W_IDLE : W_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            W_WAIT: begin
                if (cnt == wait_q - 1'b1) begin
                    phase_n = W_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        if (accept) begin
            phase_n = W_XFER;
            cnt_n   = '0;
        end
        e_n = (phase_n == W_XFER) && (cnt_n >= TIMER_W'(2)) && (cnt_n < TIMER_W'(2 + T_E_HIGH));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= W_IDLE;
            cnt    <= '0;
            wait_q <= '0;
            lcd_d  <= 4'h0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
        end else begin
            phase <= phase_n;
            cnt   <= cnt_n;
            lcd_e <= e_n;
            if (accept) begin
                lcd_d  <= nibble;
                lcd_rs <= rs;
                wait_q <= wait_cycles;
            end
        end
    end

endmodule

// File: rtl/lcd_text_driver.sv
// 32-character text buffer plus the HD44780 4-bit init and continuous two-line refresh sequencer.
module lcd_text_driver
    import lcd_text_pkg::*;
#(
    parameter int T_POWERUP    = DEF_T_POWERUP,
    parameter int T_4100US     = DEF_T_4100US,
    parameter int T_100US      = DEF_T_100US,
    parameter int T_40US       = DEF_T_40US,
    parameter int T_1640US     = DEF_T_1640US,
    parameter int T_E_HIGH     = DEF_T_E_HIGH,
    parameter int T_NIBBLE_GAP = DEF_T_NIBBLE_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_en,
    input  logic [4:0] location,
    input  logic [7:0] data,
    output logic [7:0] read_data,
    output logic       init_done,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    logic [7:0] buffer [BUF_DEPTH];

    lcd_state_t         state, state_n;
    logic [1:0]         step, step_n;
    logic               lower, lower_n;
    logic [4:0]         ref_idx, idx_n;
    logic [7:0]         char_q, char_n;
    logic [TIMER_W-1:0] cnt, cnt_n;

    logic               start, nib_rs, done;
    logic [3:0]         nib;
    logic [TIMER_W-1:0] wait_cycles;
    logic               issue_up, issue_lo, up_rs;
    logic [7:0]         up_byte;

    assign read_data = buffer[location];
    assign init_done = (state == REF_ADDR) || (state == REF_CHAR);
    assign lcd_rw    = 1'b0;

    // NOTE: the buffer must come out of reset as spaces, so unlike a RAM every entry is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= 8'h20;
        end else if (write_en) begin
            buffer[location] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PWR_WAIT;
            step    <= 2'd0;
            lower   <= 1'b0;
            ref_idx <= 5'd0;
            char_q  <= 8'h00;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            lower   <= lower_n;
            ref_idx <= idx_n;
            char_q  <= char_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        step_n      = step;
        lower_n     = lower;
        idx_n       = ref_idx;
        char_n      = char_q;
        cnt_n       = cnt;
        start       = 1'b0;
        nib         = 4'h0;
        nib_rs      = 1'b0;
        wait_cycles = '0;
        issue_up    = 1'b0;
        issue_lo    = 1'b0;
        up_byte     = 8'h00;
        up_rs       = 1'b0;

        unique case (state)
            PWR_WAIT: begin
                if (cnt == TIMER_W'(T_POWERUP - 1)) begin
                    state_n     = INIT_NIB;
                    step_n      = 2'd0;
                    cnt_n       = '0;
                    start       = 1'b1;
                    nib         = 4'h3;
                    wait_cycles = TIMER_W'(T_4100US);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            INIT_NIB: begin
                if (done) begin
                    if (step == 2'd3) begin
                        state_n  = CFG;
                        step_n   = 2'd0;
                        issue_up = 1'b1;
                        up_byte  = cfg_byte(2'd0);
                    end else begin
                        step_n      = step + 1'b1;
                        start       = 1'b1;
                        nib         = (step == 2'd2) ? 4'h2 : 4'h3;
                        wait_cycles = (step == 2'd0) ? TIMER_W'(T_100US) : TIMER_W'(T_40US);
                    end
                end
            end
            CFG: begin
                if (done) begin
                    if (!lower) begin
                        issue_lo = 1'b1;
                    end else if (step == 2'd3) begin
                        state_n = CLR_WAIT;
                        cnt_n   = '0;
                    end else begin
                        step_n   = step + 1'b1;
                        issue_up = 1'b1;
                        up_byte  = cfg_byte(step + 2'd1);
                    end
                end
            end
            CLR_WAIT: begin
                if (cnt == TIMER_W'(T_1640US - 1)) begin
                    state_n  = REF_ADDR;
                    cnt_n    = '0;
                    issue_up = 1'b1;
                    up_byte  = line_cmd(ref_idx);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REF_ADDR: begin
                if (done) begin
                    if (!lower) begin
                        issue_lo = 1'b1;
                    end else begin
                        state_n  = REF_CHAR;
                        issue_up = 1'b1;
                        up_byte  = buffer[ref_idx];
                        up_rs    = 1'b1;
                    end
                end
            end
            REF_CHAR: begin
                if (done) begin
                    if (!lower) begin
                        issue_lo = 1'b1;
                    end else begin
                        // Crossing 15->16 or 31->0 re-addresses the next line first.
                        idx_n    = ref_idx + 5'd1;
                        issue_up = 1'b1;
                        if (idx_n[3:0] == 4'd0) begin
                            state_n = REF_ADDR;
                            up_byte = line_cmd(idx_n);
                        end else begin
                            up_byte = buffer[idx_n];
                            up_rs   = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // The whole byte is captured with its upper nibble; the lower nibble reuses it.
        if (issue_up) begin
            start       = 1'b1;
            nib         = up_byte[7:4];
            nib_rs      = up_rs;
            wait_cycles = TIMER_W'(T_NIBBLE_GAP);
            lower_n     = 1'b0;
            char_n      = up_byte;
        end
        if (issue_lo) begin
            start       = 1'b1;
            nib         = char_q[3:0];
            nib_rs      = (state == REF_CHAR);
            wait_cycles = TIMER_W'(T_40US);
            lower_n     = 1'b1;
        end
    end

    lcd_nibble_writer #(
        .T_E_HIGH (T_E_HIGH)
    ) u_writer (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nibble      (nib),
        .rs          (nib_rs),
        .wait_cycles (wait_cycles),
        .done        (done),
        .lcd_d       (lcd_d),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs)
    );

endmodule
